cache_line_fill: RTL
====================

Name: cache_line_fill

Overview:
- ROM-side responder for the instruction-cache fetch request path.
- When the cache front end raises fetch_req for a missed line, this block reads LINE_BYTES consecutive bytes from ROM under the romrdy handshake.
- It writes each byte into the 512-byte cache RAM, then pulses the tag-set strobe so the front end's tag latch for that line becomes valid.
- Sits between the cache front end, the ROM bus arbiter and the cache RAM write port.

Parameters:
LINE_BYTES, 8, bytes per cache line (power of two); byte counter width = log2(LINE_BYTES)
NUM_LINES, 64, cache lines; line index width = log2(NUM_LINES)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  fill request from cache front end, level, sampled only in IDLE
fill_line  input  6  cache line index to fill, latched with fetch_req
fill_addr  input  16  ROM address of missed byte; low 3 bits cleared on latch
fill_abort  input  1  cache_start/flush; cancels any fill in progress
rom_rd  output  1  ROM read request
rom_addr  output  16  ROM byte address, valid while rom_rd=1
romrdy  input  1  ROM data valid this cycle
rom_data  input  8  ROM read data, valid when romrdy=1
cache_we  output  1  cache RAM write strobe
cache_waddr  output  9  {line, byte} write address
cache_wdata  output  8  write data
tag_set_en  output  1  one-cycle strobe: mark tag_set line valid
tag_set  output  6  line index for tag_set_en
fill_busy  output  1  high in any state except IDLE
fill_done  output  1  one-cycle pulse coincident with tag_set_en

Behaviour:
- States: IDLE, REQ, WRITE, DONE. All outputs are registered.
- Reset:
  - State = IDLE.
  - Zero on reset: rom_rd, cache_we, tag_set_en, fill_done, fill_busy, rom_addr, cache_waddr, cache_wdata, tag_set, byte counter.
  - Reset asserted mid-fill abandons the fill immediately; no tag is set.
- IDLE:
  - If fetch_req=1 and fill_abort=0: latch base = {fill_addr[15:3],3'b000} and line = fill_line, clear counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - rom_rd=1 and rom_addr = base + counter (16-bit, wraps modulo 2^16; base 0xFFF8 covers 0xFFF8..0xFFFF).
  - If romrdy=1: capture rom_data, go to WRITE.
  - Else: hold rom_rd and rom_addr stable, with no timeout.
- WRITE:
  - cache_we=1, cache_waddr = {line, counter[2:0]}, cache_wdata = captured byte, rom_rd=0.
  - If counter = LINE_BYTES-1: go to DONE.
  - Else: counter+1, go to REQ.
- DONE:
  - tag_set_en=1, fill_done=1, tag_set = line for exactly one cycle, then go to IDLE.
  - fetch_req is not accepted in DONE; the earliest next accept is the IDLE cycle.
- Latency:
  - Each byte takes minimum 2 cycles (REQ+WRITE).
  - With romrdy held 1 and fetch_req sampled at edge k: first cache_we at cycle k+2, last at k+16, tag_set_en/fill_done at k+17.
  - Each wait cycle of romrdy adds 1 cycle.
- Bytes are written in ascending address order, one cache_we per byte, never two writes to the same address within one fill.
- fill_abort:
  - From any non-IDLE state, go to IDLE on the next edge.
  - rom_rd, cache_we, tag_set_en and fill_done are forced 0 in that next cycle.
  - Bytes already written stay in RAM but the tag is never set.
- Simultaneous events:
  - fill_abort wins over romrdy in REQ: the byte is not written.
  - fill_abort wins over DONE: no tag_set_en.
  - fill_abort wins over fetch_req in IDLE: no accept.
- romrdy outside REQ is ignored. fetch_req, fill_line and fill_addr changes while busy are ignored.

Test Plan:
- Reset mid-fill: assert rst_n=0 during REQ of byte 3 -> all outputs 0 asynchronously; after release stays IDLE with fill_busy=0, no tag_set_en.
- Basic fill, romrdy tied 1, fill_addr=0x1235, fill_line=5:
  - rom_addr sequence 0x1230..0x1237.
  - cache_waddr 0x028..0x02F with data equal to the ROM model bytes.
  - tag_set_en with tag_set=5 exactly 17 cycles after accept.
- ROM wait states, romrdy low for 3 cycles on byte 2 only -> rom_rd/rom_addr=0x1232 held 4 cycles, total fill 20 cycles, data correct.
- Address wrap, fill_addr=0xFFFD, fill_line=63 -> rom_addr 0xFFF8..0xFFFF, cache_waddr 0x1F8..0x1FF, tag_set=63.
- Abort:
  - fill_abort in the same cycle as romrdy for byte 4 -> byte 4 not written, no tag_set_en, fill_busy=0 next cycle.
  - A new fetch_req is accepted in the following IDLE cycle.
- Request while busy: toggle fetch_req and change fill_line=9 mid-fill of line 5 -> completed fill writes only line 5, tag_set=5; a held fetch_req is accepted on the IDLE cycle after DONE.

Source files
------------

// File: rtl/cache_line_fill.sv
// cache_line_fill
// ---------------------------------------------------------------------------
// ROM-side responder for instruction-cache line fills. On an accepted fetch
// request it reads LINE_BYTES consecutive ROM bytes (line-aligned base
// address) using the rom_rd/romrdy handshake, writes each byte into the
// cache RAM at {line, byte}, and then pulses tag_set_en/fill_done so the
// front end can mark the line valid. fill_abort cancels a fill at any point
// and the tag is then never set.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fetch_req, fill_line,       fill request (sampled in IDLE only), line
//   fill_addr                   index and ROM address of the missed byte
//   fill_abort                  cancel any fill in progress
//   rom_rd, rom_addr            ROM read request and byte address
//   romrdy, rom_data            ROM data valid strobe and data
//   cache_we, cache_waddr,      cache RAM write port
//   cache_wdata
//   tag_set_en, tag_set         one-cycle tag-valid strobe and line index
//   fill_busy, fill_done        busy level (non-IDLE), completion pulse
// ---------------------------------------------------------------------------
module cache_line_fill #(
  parameter int LINE_BYTES = 8,
  parameter int NUM_LINES  = 64
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          fetch_req,
  input  logic [$clog2(NUM_LINES)-1:0]                  fill_line,
  input  logic [15:0]                                   fill_addr,
  input  logic                                          fill_abort,
  output logic                                          rom_rd,
  output logic [15:0]                                   rom_addr,
  input  logic                                          romrdy,
  input  logic [7:0]                                    rom_data,
  output logic                                          cache_we,
  output logic [$clog2(NUM_LINES)+$clog2(LINE_BYTES)-1:0] cache_waddr,
  output logic [7:0]                                    cache_wdata,
  output logic                                          tag_set_en,
  output logic [$clog2(NUM_LINES)-1:0]                  tag_set,
  output logic                                          fill_busy,
  output logic                                          fill_done
);

  localparam int CW = $clog2(LINE_BYTES);
  localparam int LW = $clog2(NUM_LINES);
  localparam logic [15:0]   BASE_MASK = ~16'(LINE_BYTES - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       base_q, base_d;
  logic [LW-1:0]     line_q, line_d;
  logic              rom_rd_q, rom_rd_d;
  logic [15:0]       rom_addr_q, rom_addr_d;
  logic              cache_we_q, cache_we_d;
  logic [LW+CW-1:0]  cache_waddr_q, cache_waddr_d;
  logic [7:0]        cache_wdata_q, cache_wdata_d;
  logic              tag_set_en_q, tag_set_en_d;
  logic [LW-1:0]     tag_set_q, tag_set_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;
  logic [15:0]       rom_next;

  // Every output is a flop, so each branch computes what the outputs must
  // look like in the state being entered, not the state being left.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    line_d        = line_q;
    rom_rd_d      = 1'b0;
    rom_addr_d    = rom_addr_q;
    cache_we_d    = 1'b0;
    cache_waddr_d = cache_waddr_q;
    cache_wdata_d = cache_wdata_q;
    tag_set_en_d  = 1'b0;
    tag_set_d     = tag_set_q;
    fill_done_d   = 1'b0;
    // 16-bit sum wraps naturally for a base at the top of the ROM space
    rom_next      = base_q + 16'(cnt_q) + 16'd1;

    case (state_q)
      IDLE: begin
        if (fetch_req && !fill_abort) begin
          base_d     = fill_addr & BASE_MASK;
          line_d     = fill_line;
          cnt_d      = '0;
          state_d    = REQ;
          rom_rd_d   = 1'b1;
          rom_addr_d = fill_addr & BASE_MASK;
        end
      end
      REQ: begin
        if (romrdy) begin
          cache_wdata_d = rom_data;
          cache_waddr_d = {line_q, cnt_q};
          cache_we_d    = 1'b1;
          state_d       = WRITE;
        end else begin
          // no timeout: hold the request until the ROM answers
          rom_rd_d = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_BYTE) begin
          state_d      = DONE;
          tag_set_en_d = 1'b1;
          fill_done_d  = 1'b1;
          tag_set_d    = line_q;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          state_d    = REQ;
          rom_rd_d   = 1'b1;
          rom_addr_d = rom_next;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the state logic decided, including a
    // same-cycle romrdy or the tag strobe of a completing fill.
    if (fill_abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      rom_rd_d     = 1'b0;
      cache_we_d   = 1'b0;
      tag_set_en_d = 1'b0;
      fill_done_d  = 1'b0;
    end

    fill_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      base_q        <= '0;
      line_q        <= '0;
      rom_rd_q      <= 1'b0;
      rom_addr_q    <= '0;
      cache_we_q    <= 1'b0;
      cache_waddr_q <= '0;
      cache_wdata_q <= '0;
      tag_set_en_q  <= 1'b0;
      tag_set_q     <= '0;
      fill_busy_q   <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      line_q        <= line_d;
      rom_rd_q      <= rom_rd_d;
      rom_addr_q    <= rom_addr_d;
      cache_we_q    <= cache_we_d;
      cache_waddr_q <= cache_waddr_d;
      cache_wdata_q <= cache_wdata_d;
      tag_set_en_q  <= tag_set_en_d;
      tag_set_q     <= tag_set_d;
      fill_busy_q   <= fill_busy_d;
      fill_done_q   <= fill_done_d;
    end
  end

  assign rom_rd      = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign cache_we    = cache_we_q;
  assign cache_waddr = cache_waddr_q;
  assign cache_wdata = cache_wdata_q;
  assign tag_set_en  = tag_set_en_q;
  assign tag_set     = tag_set_q;
  assign fill_busy   = fill_busy_q;
  assign fill_done   = fill_done_q;

endmodule
